alu_control_seq: RTL
====================

Name: alu_control_seq

Overview:
Multi-cycle fetch/decode/execute sequencer that sits directly upstream of the 8-bit ALU. It fetches instruction bytes over a req/ack memory port and decodes them. It drives the ALU operands and 4-bit operation code, then registers the ALU sum into the accumulator and zero flag. It also owns the program counter, jumps and halt.

Parameters:
PC_RESET, 8'h00, program counter value after reset.
ADDR_W, 8, memory address width; the PC wraps modulo 2^ADDR_W.

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; leaves IDLE. Ignored in all other states.
mem_req  out  1  fetch request.
mem_addr  out  ADDR_W  fetch address, equal to the PC.
mem_ack  in  1  read data valid. Sampled only while mem_req=1.
mem_rdata  in  8  byte read, valid with mem_ack.
alu_a  out  8  ALU operand a; always equals acc.
alu_b  out  8  ALU operand b; always equals the operand register.
alu_op  out  4  ALU operation; non-zero only in EXEC.
alu_result  in  8  ALU sum output (combinational).
acc  out  8  accumulator.
zero_flag  out  1  set when the last acc write was 8'h00.
retire  out  1  one-cycle pulse on the last cycle of each instruction.
illegal  out  1  sticky; set by an undefined opcode.
halted  out  1  high in HALT.

Behaviour:
Clock, reset and reset values:
- Reset is asynchronous and active-low; clock is clk.
- While rst_n=0: state=IDLE, pc=PC_RESET, ir=0, opnd=0, acc=0, zero_flag=0, illegal=0.
- All outputs are 0 during reset except mem_addr=PC_RESET.
- Reset asserted mid-handshake or mid-instruction aborts immediately. No acc or pc update completes.

Instruction byte format:
- opcode = ir[7:4]; ir[3:0] is ignored.
- An "imm" is the next byte fetched.
- 0x0 NOP.
- 0x1 ADD imm, 0x2 SUB imm, 0x3 OR imm, 0x4 AND imm, 0x5 XOR imm: alu_op = opcode.
- 0x6 NOT: alu_op=4'b0110, no imm.
- 0x7 LDI imm: acc<=imm, no ALU use.
- 0x8 JMP imm: pc<=imm.
- 0x9 JZ imm: if zero_flag, pc<=imm; else continue.
- 0xF HLT.
- Other opcodes (0xA–0xE): treated as NOP and set illegal.

FSM states:
- IDLE: on start -> FETCH.
- FETCH: mem_req=1, mem_addr=pc, held until mem_ack. On ack: ir<=mem_rdata, pc<=pc+1 -> DECODE.
- DECODE (1 cycle):
  - Opcodes with imm -> FETCH_OP.
  - NOT -> EXEC.
  - HLT -> HALT.
  - NOP/illegal -> FETCH, with retire pulse.
- FETCH_OP: same handshake as FETCH. On ack: opnd<=mem_rdata, pc<=pc+1.
  - JMP: pc<=mem_rdata instead; retire -> FETCH.
  - JZ taken: pc<=mem_rdata instead; retire -> FETCH.
  - JZ not taken: retire -> FETCH.
  - LDI: acc<=mem_rdata, zero_flag<=(mem_rdata==0); retire -> FETCH.
  - ALU opcodes -> EXEC.
- EXEC (1 cycle): alu_op driven, acc<=alu_result, zero_flag<=(alu_result==0); retire -> FETCH.
- HALT: halted=1, mem_req=0. Left only by reset.

Handshake:
- mem_req rises on entry to FETCH/FETCH_OP and stays high until mem_ack is sampled.
- mem_req is low the cycle after the ack.
- Any number of wait states is allowed.
- mem_ack while mem_req=0 is ignored.

Timing with zero wait states (mem_ack tied high):
- NOP: 2 cycles.
- NOT: 3 cycles.
- LDI/JMP/JZ: 3 cycles.
- ALU op with imm: 4 cycles.
- Each wait state adds 1 cycle.

Width rules:
- pc+1 wraps (0xFF -> 0x00 at ADDR_W=8).
- ALU carry is not used; results are 8-bit and truncated.

Test Plan:
1. Reset, start, ack tied high; program 70 05 10 03 F0 -> acc=8'h08, zero_flag=0, halted=1. Retire pulses at cycles 3 and 7 after FETCH entry.
2. Program 70 08 20 08 90 10 F0, byte@0x10=F0 -> acc=0, zero_flag=1, JZ taken, next fetch addr 0x10, halted. With LDI 09 instead: JZ not taken, fetch addr 0x06.
3. Program 70 0F 60 50 F0 F0 -> NOT gives acc=F0. XOR F0 gives acc=00, zero_flag=1. During the NOT EXEC cycle, alu_op=0110 for exactly 1 cycle.
4. mem_ack delayed 3 cycles per fetch -> mem_req held high with mem_addr stable. Same final acc as scenario 1. ADD instruction takes 4+6 cycles.
5. Opcode A0 then F0 -> illegal=1 and stays set, acc unchanged, halted. start pulsed in HALT and mid-instruction -> no effect.
6. rst_n low during a FETCH_OP wait state -> mem_req=0 and acc=0 immediately, without waiting for a clock. After release, fetch restarts at PC_RESET. JMP FF then wrap: PC after fetching 0xFF is 0x00.

Source files
------------

// File: rtl/alu_control_seq.sv
// Fetch/decode/execute sequencer feeding an external 8-bit ALU.
// Owns the PC, instruction and operand registers, accumulator and zero flag.
module alu_control_seq #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_op,
    input  logic [7:0]        alu_result,
    output logic [7:0]        acc,
    output logic              zero_flag,
    output logic              retire,
    output logic              illegal,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_FETCH_OP,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [7:0]        ir_reg, ir_next;
    logic [7:0]        opnd_reg, opnd_next;
    logic [7:0]        acc_reg, acc_next;
    logic              zero_reg, zero_next;
    logic              illegal_reg, illegal_next;
    logic              retire_next;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] pc_inc;

    assign opcode = ir_reg[7:4];
    assign pc_inc = pc_reg + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            pc_reg      <= PC_RESET;
            ir_reg      <= '0;
            opnd_reg    <= '0;
            acc_reg     <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            opnd_reg    <= opnd_next;
            acc_reg     <= acc_next;
            zero_reg    <= zero_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        opnd_next    = opnd_reg;
        acc_next     = acc_reg;
        zero_next    = zero_reg;
        illegal_next = illegal_reg;
        retire_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_next    = mem_rdata;
                    pc_next    = pc_inc;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                    OP_LDI, OP_JMP, OP_JZ: state_next = S_FETCH_OP;
                    OP_NOT:                state_next = S_EXEC;
                    OP_HLT:                state_next = S_HALT;
                    OP_NOP: begin
                        retire_next = 1'b1;
                        state_next  = S_FETCH;
                    end
                    default: begin
                        illegal_next = 1'b1;
                        retire_next  = 1'b1;
                        state_next   = S_FETCH;
                    end
                endcase
            end
            S_FETCH_OP: begin
                if (mem_ack) begin
                    opnd_next = mem_rdata;
                    pc_next   = pc_inc;
                    case (opcode)
                        OP_LDI: begin
                            acc_next    = mem_rdata;
                            zero_next   = (mem_rdata == 8'h00);
                            retire_next = 1'b1;
                            state_next  = S_FETCH;
                        end
                        OP_JMP: begin
                            pc_next     = ADDR_W'(mem_rdata);
                            retire_next = 1'b1;
                            state_next  = S_FETCH;
                        end
                        OP_JZ: begin
                            // Branch decision uses the flag from the previous acc write.
                            if (zero_reg) pc_next = ADDR_W'(mem_rdata);
                            retire_next = 1'b1;
                            state_next  = S_FETCH;
                        end
                        default: state_next = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                acc_next    = alu_result;
                zero_next   = (alu_result == 8'h00);
                retire_next = 1'b1;
                state_next  = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decode from state so reset clears them without waiting for a clock.
    assign mem_req   = (state_reg == S_FETCH) || (state_reg == S_FETCH_OP);
    assign mem_addr  = pc_reg;
    assign alu_a     = acc_reg;
    assign alu_b     = opnd_reg;
    assign alu_op    = (state_reg == S_EXEC) ? opcode : 4'h0;
    assign acc       = acc_reg;
    assign zero_flag = zero_reg;
    assign retire    = retire_next;
    assign illegal   = illegal_reg;
    assign halted    = (state_reg == S_HALT);

endmodule
